// File: rtl/add12u_arb_pkg.sv
// Shared types and constants for the add12u_share_arb slice.
package add12u_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    localparam int OPW   = 12;
    localparam int SUMW  = 13;
    localparam int STATW = 16;

    // Increment a grant counter, sticking at all-ones instead of wrapping.
    function automatic logic [STATW-1:0] sat_inc(input logic [STATW-1:0] v);
        logic [STATW-1:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/add12u_core.sv
// Exact 12-bit unsigned ripple-carry adder: one half adder at bit 0,
// eleven full adders above it, carry-out lands in O[12].
module add12u_core
    import add12u_arb_pkg::*;
(
    input  logic [OPW-1:0]  A,
    input  logic [OPW-1:0]  B,
    output logic [SUMW-1:0] O
);

    logic [OPW-1:0] carry_s;   // carry out of each bit position

    assign O[0]       = A[0] ^ B[0];
    assign carry_s[0] = A[0] & B[0];

    genvar i;
    generate
        for (i = 1; i < OPW; i++) begin : g_fa
            assign O[i]       = A[i] ^ B[i] ^ carry_s[i-1];
            assign carry_s[i] = (A[i] & B[i]) | (carry_s[i-1] & (A[i] ^ B[i]));
        end
    endgenerate

    assign O[OPW] = carry_s[OPW-1];

endmodule

// File: rtl/add12u_share_arb.sv
// Round-robin sequencer sharing one add12u_core among NREQ requesters.
// A granted request's operands are latched, held for LAT cycles while the
// adder output settles (multicycle path), then the sum is registered and
// presented until the consumer accepts it.
// Optional build macro ADD12U_ARB_STATS_EN adds per-requester grant counters
// (stat_cnt) with a synchronous clear input (stat_clr).
module add12u_share_arb
    import add12u_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int LAT  = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [OPW*NREQ-1:0]   req_a,
    input  logic [OPW*NREQ-1:0]   req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [SUMW-1:0]       rsp_sum,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy
`ifdef ADD12U_ARB_STATS_EN
    ,
    input  logic                  stat_clr,
    output logic [STATW*NREQ-1:0] stat_cnt
`endif
);

    localparam logic [IDW:0] NREQ_W   = (IDW+1)'(NREQ);
    localparam logic [3:0]   LAT_LOAD = 4'(LAT - 1);

    arb_state_t      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [OPW-1:0]  a_q, a_d;
    logic [OPW-1:0]  b_q, b_d;
    logic [SUMW-1:0] sum_q, sum_d;
    logic [SUMW-1:0] add_o_s;
    logic            gnt_found_s;
    logic [IDW-1:0]  gnt_idx_s;
    logic [IDW-1:0]  cand_s;

    // (p + off) mod NREQ for p, off < NREQ.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p,
                                                input logic [IDW-1:0] off);
        logic [IDW:0] t;
        t = {1'b0, p} + {1'b0, off};
        if (t >= NREQ_W) begin
            t = t - NREQ_W;
        end else begin
            t = t;
        end
        return t[IDW-1:0];
    endfunction

    // The adder only ever sees the latched operands, so its paths stay
    // static for the whole settle window.
    add12u_core u_core (
        .A (a_q),
        .B (b_q),
        .O (add_o_s)
    );

    // Round-robin search: first valid requester at or after rr_q, wrapping.
    // Grants exist only in IDLE and never while reset is asserted.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        cand_s      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s = wrap_add(rr_q, IDW'(i));
            if (!gnt_found_s && req_valid[cand_s] &&
                (state_q == ST_IDLE) && rst_n) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = cand_s;
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    // One-hot grant, asserted only in the accept cycle.
    always_comb begin
        req_ready = '0;
        if (gnt_found_s) begin
            req_ready[gnt_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // FSM next-state: IDLE -> SETTLE -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_found_s) begin
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: operand/id latch on accept, settle countdown,
    // sum capture when the countdown expires, pointer advance past the grant.
    always_comb begin
        cnt_d = cnt_q;
        rr_d  = rr_q;
        id_d  = id_q;
        a_d   = a_q;
        b_d   = b_q;
        sum_d = sum_q;
        if (gnt_found_s) begin
            a_d   = req_a[OPW*gnt_idx_s +: OPW];
            b_d   = req_b[OPW*gnt_idx_s +: OPW];
            id_d  = gnt_idx_s;
            cnt_d = LAT_LOAD;
            rr_d  = wrap_add(gnt_idx_s, IDW'(1));
        end else if (state_q == ST_SETTLE) begin
            if (cnt_q == 4'd0) begin
                sum_d = add_o_s;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rr_q    <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    // Outputs decoded from registered state; sum/id come straight from flops.
    always_comb begin
        rsp_valid = (state_q == ST_RESP);
        busy      = (state_q != ST_IDLE);
        rsp_sum   = sum_q;
        rsp_id    = id_q;
    end

`ifdef ADD12U_ARB_STATS_EN
    logic [STATW-1:0] stat_q [NREQ];
    logic [STATW-1:0] stat_d [NREQ];

    // Grant counters: clear wins over a same-cycle grant, otherwise saturate.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            if (stat_clr) begin
                stat_d[i] = '0;
            end else if (gnt_found_s && (gnt_idx_s == IDW'(i))) begin
                stat_d[i] = sat_inc(stat_q[i]);
            end else begin
                stat_d[i] = stat_q[i];
            end
        end
    end

    // Grant counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

    // Pack counters onto the flat output bus, requester i at [16*i +: 16].
    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            stat_cnt[STATW*i +: STATW] = stat_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_add12u_share_arb.sv
// Scoreboard bench for add12u_share_arb (NREQ=4, LAT=2). A reference model
// predicts grants from round-robin rules and pushes expected {id, A+B};
// a separate monitor pops on each response handshake.
module tb_add12u_share_arb;

    localparam int NREQ = 4;
    localparam int LAT  = 2;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [47:0] req_a;
    logic [47:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [12:0] rsp_sum;
    logic [1:0]  rsp_id;
    logic        busy;
`ifdef ADD12U_ARB_STATS_EN
    logic        stat_clr;
    logic [63:0] stat_cnt;
`endif

    add12u_share_arb #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .busy      (busy)
`ifdef ADD12U_ARB_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .stat_cnt  (stat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int id; logic [12:0] sum; } exp_t;
    exp_t   sbq[$];
    int     glog[$];
    longint gcyc[$];

    // model state (written only by the model process)
    int m_rr = 0;
    bit m_busy = 1'b0;
    int m_cnt = 0;
    int gseq = 0;
    int last_g = 0;
    int gcnt[4];

    // stimulus state (written only by the main process)
    bit        pend[4];
    logic [11:0] opa[4];
    logic [11:0] opb[4];
    int  seen_seq = 0;
    bit  hold_all = 1'b0;
    int  rdy_mode = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: round-robin grant prediction and response timing.
    always @(negedge clk) begin
        int g;
        int c;
        logic [3:0] er;
        if (!rst_n) begin
            m_rr = 0;
            m_busy = 1'b0;
            m_cnt = 0;
            sbq.delete();
            for (int i = 0; i < 4; i++) gcnt[i] = 0;
        end else begin
            chk("rsp_valid_timing", {31'd0, rsp_valid}, {31'd0, (m_busy && m_cnt == 0)});
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
`ifdef ADD12U_ARB_STATS_EN
            for (int i = 0; i < 4; i++)
                chk($sformatf("stat_cnt[%0d]", i), {16'd0, stat_cnt[16*i +: 16]}, gcnt[i]);
`endif
            g = -1;
            if (!m_busy) begin
                for (int k = 0; k < 4; k++) begin
                    c = (m_rr + k) % 4;
                    if (g < 0 && req_valid[c]) g = c;
                end
            end
            er = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            chk("req_ready", {28'd0, req_ready}, {28'd0, er});
`ifdef ADD12U_ARB_STATS_EN
            if (stat_clr) begin
                for (int i = 0; i < 4; i++) gcnt[i] = 0;
            end else if (g >= 0 && gcnt[g] < 65535) begin
                gcnt[g] = gcnt[g] + 1;
            end
`endif
            if (m_busy) begin
                if (m_cnt == 0) begin
                    if (rsp_ready) m_busy = 1'b0;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end else if (g >= 0) begin
                sbq.push_back('{g, 13'(req_a[12*g +: 12]) + 13'(req_b[12*g +: 12])});
                m_rr = (g + 1) % 4;
                m_busy = 1'b1;
                m_cnt = LAT;
                last_g = g;
                gseq = gseq + 1;
                glog.push_back(g);
                gcyc.push_back(cyc);
            end
        end
    end

    // Monitor: pop and compare on handshake; hold-stability while stalled.
    bit          h_pend = 1'b0;
    logic [12:0] h_sum;
    logic [1:0]  h_id;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            h_pend = 1'b0;
        end else begin
            if (h_pend) begin
                chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
                chk("stall_sum", {19'd0, rsp_sum}, {19'd0, h_sum});
                chk("stall_id", {30'd0, rsp_id}, {30'd0, h_id});
            end
            if (rsp_valid && rsp_ready) begin
                n_checks++;
                if (sbq.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_rsp: got id %0d sum %0h, expected none", rsp_id, rsp_sum);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_id", {30'd0, rsp_id}, e.id);
                    chk("rsp_sum", {19'd0, rsp_sum}, {19'd0, e.sum});
                end
            end
            h_pend = rsp_valid && !rsp_ready;
            h_sum  = rsp_sum;
            h_id   = rsp_id;
        end
    end

    function automatic logic [11:0] rnd_op();
        logic [11:0] v;
        v = ($urandom % 8 == 0) ? 12'hFFF : 12'($urandom);
        return v;
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]        = pend[i];
            req_a[12*i +: 12]   = opa[i];
            req_b[12*i +: 12]   = opb[i];
        end
    endtask

    task automatic issue(input int i, input logic [11:0] a, input logic [11:0] b);
        pend[i] = 1'b1;
        opa[i]  = a;
        opb[i]  = b;
        drive();
    endtask

    // One clock: retire the last grant, optionally randomise, drive inputs.
    task automatic step(input bit rnd);
        @(posedge clk);
        #1;
        if (gseq != seen_seq) begin
            seen_seq = gseq;
            if (hold_all) begin
                opa[last_g] = rnd_op();
                opb[last_g] = rnd_op();
            end else begin
                pend[last_g] = 1'b0;
            end
        end
        if (rnd) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i]) begin
                    if ($urandom % 4 == 0) begin
                        pend[i] = 1'b1;
                        opa[i]  = rnd_op();
                        opb[i]  = rnd_op();
                    end
                end else if ($urandom % 40 == 0) begin
                    pend[i] = 1'b0;
                end
            end
        end
        rsp_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom % 3 != 0);
`ifdef ADD12U_ARB_STATS_EN
        stat_clr = rnd && ($urandom % 50 == 0);
`endif
        drive();
    endtask

    task automatic wait_valid(input string name, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            step(1'b0);
            if (rsp_valid) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got no rsp_valid, expected one within 20 cycles", name);
        end
    endtask

    task automatic directed(input string name, input int i, input logic [11:0] a,
                            input logic [11:0] b, input logic [12:0] exp);
        bit ok;
        issue(i, a, b);
        wait_valid(name, ok);
        if (ok) begin
            chk({name, "_sum"}, {19'd0, rsp_sum}, {19'd0, exp});
            chk({name, "_id"}, {30'd0, rsp_id}, i);
        end
        repeat (3) step(1'b0);
    endtask

    initial begin
        bit ok;
        int base;
        int eo[5];
        eo = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        req_valid = 4'b0000;
        req_a = 48'd0;
        req_b = 48'd0;
        rsp_ready = 1'b1;
`ifdef ADD12U_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        for (int i = 0; i < 4; i++) begin
            pend[i] = 1'b0; opa[i] = 12'd0; opb[i] = 12'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", {28'd0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_sum", {19'd0, rsp_sum}, 32'd0);
        chk("reset_rsp_id", {30'd0, rsp_id}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        // basic sums and carry-out boundaries
        directed("t1", 0, 12'h123, 12'h456, 13'h0579);
        directed("t2a", 1, 12'hFFF, 12'h001, 13'h1000);
        directed("t2b", 2, 12'hFFF, 12'hFFF, 13'h1FFE);
        directed("t2c", 3, 12'h000, 12'h000, 13'h0000);

        // consumer stalls 5 cycles with requests pending
        rdy_mode = 2;
        issue(1, 12'hABC, 12'h111);
        issue(3, 12'h800, 12'h800);
        wait_valid("t4", ok);
        repeat (5) step(1'b0);
        rdy_mode = 0;
        repeat (12) step(1'b0);

        // reset during SETTLE, then all four held high
        hold_all = 1'b1;
        for (int i = 0; i < 4; i++) issue(i, rnd_op(), rnd_op());
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            step(1'b0);
            if (busy && !rsp_valid) ok = 1'b1;
        end
        rst_n = 1'b0;
        #1;
        chk("t5_req_ready", {28'd0, req_ready}, 32'd0);
        chk("t5_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t5_rsp_sum", {19'd0, rsp_sum}, 32'd0);
        chk("t5_rsp_id", {30'd0, rsp_id}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        base = glog.size();
        rst_n = 1'b1;
        repeat (5 * (LAT + 2) + 2) step(1'b0);
        n_checks++;
        if (glog.size() < base + 5) begin
            n_errors++;
            $display("FAIL t3_grant_count: got %0d grants, expected at least 5", glog.size() - base);
        end else begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("t3_order[%0d]", i), glog[base + i], eo[i]);
                if (i > 0) chk($sformatf("t3_spacing[%0d]", i),
                               32'(gcyc[base + i] - gcyc[base + i - 1]), LAT + 2);
            end
        end
        hold_all = 1'b0;

        // randomized traffic with random backpressure
        rdy_mode = 1;
        repeat (1500) step(1'b1);

        // drain
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) pend[i] = 1'b0;
        drive();
        repeat (30) step(1'b0);
        chk("scoreboard_drained", sbq.size(), 32'd0);

`ifdef ADD12U_ARB_STATS_EN
        stat_clr = 1'b1;
        step(1'b0);
        repeat (3) directed("t6", 1, rnd_op(), rnd_op(), 13'd0 + 13'(opa[1]) + 13'(opb[1]));
        chk("t6_cnt3", {16'd0, stat_cnt[16 +: 16]}, 32'd3);
        issue(1, 12'h001, 12'h002);
        stat_clr = 1'b1;
        step(1'b0);
        chk("t6_clr_wins", {16'd0, stat_cnt[16 +: 16]}, 32'd0);
        repeat (10) step(1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
